// File: rtl/ttm4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttm4_pkg
// Description : Shared constants, instruction field layout and loader FSM
//               state encoding for the TTM4 program memory.
// Revision    : 1.0
// ============================================================================
package ttm4_pkg;

    localparam int c_DATA_W = 15;
    localparam int c_ADDR_W = 8;

    // Instruction word layout: OP[14:10] SR[9:7] LR[6:4] IM[3:0]
    localparam int c_OP_LSB = 10;
    localparam int c_OP_W   = 5;
    localparam int c_SR_LSB = 7;
    localparam int c_SR_W   = 3;
    localparam int c_LR_LSB = 4;
    localparam int c_LR_W   = 3;
    localparam int c_IM_LSB = 0;
    localparam int c_IM_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ttm4_prog_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : ttm4_prog_mem_if
// Description : Host strobe, loader stream and CPU fetch signals of the
//               TTM4 program memory.
// Revision    : 1.0
// ============================================================================
interface ttm4_prog_mem_if #(
    parameter int DATA_W = 15,
    parameter int ADDR_W = 8
);
    logic              nWE;
    logic              nOE;
    logic [ADDR_W-1:0] ADD;
    logic [DATA_W-1:0] DIN;
    logic [DATA_W-1:0] DOUT;
    logic              DOUT_VALID;
    logic              LD_START;
    logic [ADDR_W-1:0] LD_BASE;
    logic              LD_VALID;
    logic [DATA_W-1:0] LD_DATA;
    logic              LD_LAST;
    logic              LD_READY;
    logic              LD_DONE;
    logic [ADDR_W:0]   LD_COUNT;
    logic              FETCH_EN;
    logic [ADDR_W-1:0] FETCH_ADDR;
    logic [DATA_W-1:0] FETCH_DATA;
    logic              FETCH_VALID;
    logic              WR_DROP;

    modport master (
        output nWE, nOE, ADD, DIN, LD_START, LD_BASE, LD_VALID, LD_DATA,
               LD_LAST, FETCH_EN, FETCH_ADDR,
        input  DOUT, DOUT_VALID, LD_READY, LD_DONE, LD_COUNT, FETCH_DATA,
               FETCH_VALID, WR_DROP
    );

    modport slave (
        input  nWE, nOE, ADD, DIN, LD_START, LD_BASE, LD_VALID, LD_DATA,
               LD_LAST, FETCH_EN, FETCH_ADDR,
        output DOUT, DOUT_VALID, LD_READY, LD_DONE, LD_COUNT, FETCH_DATA,
               FETCH_VALID, WR_DROP
    );
endinterface
`default_nettype wire

// File: rtl/ttm4_dpram.sv
`default_nettype none
// ============================================================================
// Module      : ttm4_dpram
// Description : One-write, two-read synchronous RAM, read-before-write,
//               storage not reset; out-of-range reads return zero.
// Revision    : 1.0
// ============================================================================
module ttm4_dpram #(
    parameter int DATA_W = 15,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re_a,
    input  wire logic [ADDR_W-1:0] i_raddr_a,
    output logic      [DATA_W-1:0] o_rdata_a,
    input  wire logic              i_re_b,
    input  wire logic [ADDR_W-1:0] i_raddr_b,
    output logic      [DATA_W-1:0] o_rdata_b
);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic              w_wr_ok;
    logic              w_rd_ok_a;
    logic              w_rd_ok_b;

    assign w_wr_ok   = ({1'b0, i_waddr}   < c_DEPTH);
    assign w_rd_ok_a = ({1'b0, i_raddr_a} < c_DEPTH);
    assign w_rd_ok_b = ({1'b0, i_raddr_b} < c_DEPTH);

    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read registers see the pre-write contents on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (i_re_a) r_rdata_a <= w_rd_ok_a ? r_mem[i_raddr_a] : '0;
            if (i_re_b) r_rdata_b <= w_rd_ok_b ? r_mem[i_raddr_b] : '0;
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;
endmodule
`default_nettype wire

// File: rtl/ttm4_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : ttm4_prog_mem
// Description : TTM4 program memory with strobe host port, burst loader and
//               CPU fetch port sharing one dual-read RAM.
// Revision    : 1.0
// ============================================================================
module ttm4_prog_mem
    import ttm4_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input wire logic         CLK,
    input wire logic         RST,
    ttm4_prog_mem_if.slave   bus
);
    localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_PTR_LAST  = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W:0]   c_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ld_ready;
    logic              r_ld_done;
    logic              r_nwe_q, r_noe_q;
    logic              r_hwr_pend, r_hrd_pend;
    logic [ADDR_W-1:0] r_hwr_addr, r_hrd_addr;
    logic [DATA_W-1:0] r_hwr_data;
    logic              r_wr_drop, r_dout_valid, r_fetch_valid;

    logic              w_we_fall, w_oe_fall, w_hwr_ok, w_ld_acc;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W:0]   w_count_next;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;

    assign w_we_fall = r_nwe_q & ~bus.nWE;
    assign w_oe_fall = r_noe_q & ~bus.nOE;
    // Refusing host writes on a LD_START edge keeps them from colliding with loader words.
    assign w_hwr_ok  = w_we_fall && (r_state == ST_IDLE) && !bus.LD_START
                       && ({1'b0, bus.ADD} < c_DEPTH);
    assign w_ld_acc  = r_ld_ready && bus.LD_VALID && !bus.LD_START;

    assign w_ptr_next   = (r_ptr == c_PTR_LAST) ? '0 : r_ptr + ADDR_W'(1);
    assign w_count_next = (r_count == c_COUNT_MAX) ? r_count : r_count + (ADDR_W+1)'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_ld_ready <= 1'b0;
            r_ld_done  <= 1'b0;
        end else begin
            r_ld_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.LD_START) begin
                        r_state    <= ST_LOAD;
                        r_ptr      <= bus.LD_BASE;
                        r_count    <= '0;
                        r_ld_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.LD_START) begin
                        r_ptr   <= bus.LD_BASE;
                        r_count <= '0;
                    end else if (w_ld_acc) begin
                        r_ptr   <= w_ptr_next;
                        r_count <= w_count_next;
                        if (bus.LD_LAST) begin
                            r_state    <= ST_FLUSH;
                            r_ld_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state   <= ST_IDLE;
                    r_ld_done <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ld_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_nwe_q       <= 1'b1;
            r_noe_q       <= 1'b1;
            r_hwr_pend    <= 1'b0;
            r_hrd_pend    <= 1'b0;
            r_wr_drop     <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_fetch_valid <= 1'b0;
        end else begin
            r_nwe_q       <= bus.nWE;
            r_noe_q       <= bus.nOE;
            r_hwr_pend    <= w_hwr_ok;
            r_hrd_pend    <= w_oe_fall;
            r_wr_drop     <= w_we_fall && !w_hwr_ok;
            r_dout_valid  <= r_hrd_pend;
            r_fetch_valid <= bus.FETCH_EN;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we_fall) begin
            r_hwr_addr <= bus.ADD;
            r_hwr_data <= bus.DIN;
        end
        if (w_oe_fall) begin
            r_hrd_addr <= bus.ADD;
        end
    end

    assign w_ram_we    = w_ld_acc | r_hwr_pend;
    assign w_ram_waddr = w_ld_acc ? r_ptr      : r_hwr_addr;
    assign w_ram_wdata = w_ld_acc ? bus.LD_DATA : r_hwr_data;

    ttm4_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (CLK),
        .rst       (RST),
        .i_we      (w_ram_we),
        .i_waddr   (w_ram_waddr),
        .i_wdata   (w_ram_wdata),
        .i_re_a    (r_hrd_pend),
        .i_raddr_a (r_hrd_addr),
        .o_rdata_a (bus.DOUT),
        .i_re_b    (bus.FETCH_EN),
        .i_raddr_b (bus.FETCH_ADDR),
        .o_rdata_b (bus.FETCH_DATA)
    );

    assign bus.DOUT_VALID  = r_dout_valid;
    assign bus.LD_READY    = r_ld_ready;
    assign bus.LD_DONE     = r_ld_done;
    assign bus.LD_COUNT    = r_count;
    assign bus.FETCH_VALID = r_fetch_valid;
    assign bus.WR_DROP     = r_wr_drop;
endmodule
`default_nettype wire

// File: tb/tb_ttm4_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttm4_prog_mem
// Description : Directed plus randomized bench for ttm4_prog_mem against an
//               array model of the memory contents.
// Revision    : 1.0
// ============================================================================
module tb_ttm4_prog_mem;
    localparam int DW = 15;
    localparam int AW = 8;

    logic tb_CLK = 1'b0;
    logic tb_RST;
    always #5 tb_CLK = ~tb_CLK;

    ttm4_prog_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ttm4_prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) dut (
        .CLK (tb_CLK),
        .RST (tb_RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] model_mem [256];

    task automatic tick();
        @(posedge tb_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hwrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit drop);
        bus.ADD = a; bus.DIN = d; bus.nWE = 1'b0;
        tick();
        chk("wr_drop", {31'd0, bus.WR_DROP}, {31'd0, drop});
        bus.nWE = 1'b1;
        tick();
        if (!drop) model_mem[a] = d;
    endtask

    task automatic hread(input logic [AW-1:0] a, input string tag);
        bus.ADD = a; bus.nOE = 1'b0;
        tick();
        chk({tag, "_early"}, {31'd0, bus.DOUT_VALID}, 32'd0);
        bus.nOE = 1'b1;
        tick();
        chk({tag, "_valid"}, {31'd0, bus.DOUT_VALID}, 32'd1);
        chk({tag, "_data"}, {17'd0, bus.DOUT}, {17'd0, model_mem[a]});
        tick();
        chk({tag, "_pulse"}, {31'd0, bus.DOUT_VALID}, 32'd0);
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        bus.FETCH_EN = 1'b1; bus.FETCH_ADDR = a;
        tick();
        bus.FETCH_EN = 1'b0;
        chk("fetch_valid", {31'd0, bus.FETCH_VALID}, 32'd1);
        chk("fetch_data", {17'd0, bus.FETCH_DATA}, {17'd0, model_mem[a]});
        tick();
        chk("fetch_valid_off", {31'd0, bus.FETCH_VALID}, 32'd0);
        chk("fetch_hold", {17'd0, bus.FETCH_DATA}, {17'd0, model_mem[a]});
    endtask

    task automatic load_burst(input logic [AW-1:0] base, input int n, input bit seq);
        logic [AW-1:0] ptr;
        logic [DW-1:0] d;
        int exp_cnt;
        ptr = base;
        bus.LD_BASE = base; bus.LD_START = 1'b1;
        tick();
        bus.LD_START = 1'b0;
        chk("ld_ready_on", {31'd0, bus.LD_READY}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (!seq && $urandom_range(3) == 0) begin
                bus.LD_VALID = 1'b0;
                tick();
            end
            d = seq ? DW'(i + 1) : DW'($urandom);
            bus.LD_VALID = 1'b1; bus.LD_DATA = d; bus.LD_LAST = (i == n - 1);
            tick();
            model_mem[ptr] = d;
            ptr = ptr + 8'd1;
        end
        bus.LD_VALID = 1'b0; bus.LD_LAST = 1'b0;
        exp_cnt = (n > 256) ? 256 : n;
        chk("ld_ready_off", {31'd0, bus.LD_READY}, 32'd0);
        chk("ld_done_early", {31'd0, bus.LD_DONE}, 32'd0);
        tick();
        chk("ld_done", {31'd0, bus.LD_DONE}, 32'd1);
        chk("ld_count", {23'd0, bus.LD_COUNT}, 32'(exp_cnt));
        tick();
        chk("ld_done_pulse", {31'd0, bus.LD_DONE}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d0, old, d1, d2;
        logic [AW-1:0] a;

        bus.nWE = 1'b1; bus.nOE = 1'b1; bus.ADD = '0; bus.DIN = '0;
        bus.LD_START = 1'b0; bus.LD_BASE = '0; bus.LD_VALID = 1'b0;
        bus.LD_DATA = '0; bus.LD_LAST = 1'b0;
        bus.FETCH_EN = 1'b0; bus.FETCH_ADDR = '0;
        tb_RST = 1'b1;
        repeat (3) tick();

        chk("rst_dout", {17'd0, bus.DOUT}, 32'd0);
        chk("rst_dout_valid", {31'd0, bus.DOUT_VALID}, 32'd0);
        chk("rst_ld_ready", {31'd0, bus.LD_READY}, 32'd0);
        chk("rst_ld_done", {31'd0, bus.LD_DONE}, 32'd0);
        chk("rst_ld_count", {23'd0, bus.LD_COUNT}, 32'd0);
        chk("rst_fetch_data", {17'd0, bus.FETCH_DATA}, 32'd0);
        chk("rst_fetch_valid", {31'd0, bus.FETCH_VALID}, 32'd0);
        chk("rst_wr_drop", {31'd0, bus.WR_DROP}, 32'd0);
        tb_RST = 1'b0;
        tick();

        // Fill every word so later reads are fully predictable; 258 words wraps and saturates the count.
        load_burst(8'h00, 258, 1'b0);

        hwrite(8'h00, 15'h0F00, 1'b0);
        hwrite(8'h01, 15'h00F0, 1'b0);
        hwrite(8'h02, 15'h000F, 1'b0);
        hread(8'h00, "rd00");
        hread(8'h01, "rd01");
        hread(8'h02, "rd02");
        hread(8'h03, "rd03");

        d0 = DW'($urandom);
        bus.ADD = 8'h10; bus.DIN = d0; bus.nWE = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.DIN = ~d0 ^ DW'(i);
            tick();
        end
        bus.nWE = 1'b1;
        tick();
        model_mem[8'h10] = d0;
        hread(8'h10, "hold_we");

        load_burst(8'hFE, 4, 1'b1);
        hread(8'hFE, "ldFE");
        hread(8'hFF, "ldFF");
        hread(8'h00, "ld00");
        hread(8'h01, "ld01");

        bus.LD_BASE = 8'h40; bus.LD_START = 1'b1;
        tick();
        bus.LD_START = 1'b0;
        hwrite(8'h20, 15'h1234 ^ model_mem[8'h20], 1'b1);
        hread(8'h20, "drop_rd");
        d1 = DW'($urandom);
        bus.LD_VALID = 1'b1; bus.LD_DATA = d1; bus.LD_LAST = 1'b1;
        tick();
        model_mem[8'h40] = d1;
        bus.LD_VALID = 1'b0; bus.LD_LAST = 1'b0;
        tick();
        chk("drop_ld_done", {31'd0, bus.LD_DONE}, 32'd1);
        chk("drop_ld_count", {23'd0, bus.LD_COUNT}, 32'd1);
        tick();
        hread(8'h40, "drop_ld40");

        a = 8'($urandom);
        d0 = DW'($urandom);
        old = model_mem[a];
        bus.ADD = a; bus.DIN = d0; bus.nWE = 1'b0; bus.nOE = 1'b0;
        tick();
        bus.nWE = 1'b1; bus.nOE = 1'b1;
        tick();
        chk("rbw_valid", {31'd0, bus.DOUT_VALID}, 32'd1);
        chk("rbw_old", {17'd0, bus.DOUT}, {17'd0, old});
        model_mem[a] = d0;
        tick();
        hread(a, "rbw_new");

        old = model_mem[8'h01];
        bus.ADD = 8'h01; bus.DIN = 15'h7FFF; bus.nWE = 1'b0;
        tick();
        bus.nWE = 1'b1; bus.FETCH_EN = 1'b1; bus.FETCH_ADDR = 8'h01;
        tick();
        chk("fcol_valid", {31'd0, bus.FETCH_VALID}, 32'd1);
        chk("fcol_old", {17'd0, bus.FETCH_DATA}, {17'd0, old});
        model_mem[8'h01] = 15'h7FFF;
        tick();
        chk("fcol_new", {17'd0, bus.FETCH_DATA}, 32'h7FFF);
        bus.FETCH_EN = 1'b0;
        tick();
        chk("fcol_off", {31'd0, bus.FETCH_VALID}, 32'd0);
        chk("fcol_hold", {17'd0, bus.FETCH_DATA}, 32'h7FFF);

        bus.LD_BASE = 8'h80; bus.LD_START = 1'b1;
        tick();
        bus.LD_START = 1'b0;
        d1 = DW'($urandom); d2 = DW'($urandom);
        bus.LD_VALID = 1'b1; bus.LD_DATA = d1;
        tick();
        bus.LD_DATA = d2;
        tick();
        model_mem[8'h80] = d1; model_mem[8'h81] = d2;
        bus.LD_VALID = 1'b0;
        chk("mid_count", {23'd0, bus.LD_COUNT}, 32'd2);
        tb_RST = 1'b1;
        tick();
        tb_RST = 1'b0;
        chk("mid_rst_ready", {31'd0, bus.LD_READY}, 32'd0);
        chk("mid_rst_count", {23'd0, bus.LD_COUNT}, 32'd0);
        tick();
        hread(8'h80, "mid_rd80");
        hread(8'h81, "mid_rd81");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(2))
                0: hwrite(8'($urandom), DW'($urandom), 1'b0);
                1: hread(8'($urandom), "rnd_rd");
                default: fetch(8'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
